// File: rtl/search_req_ctrl_pkg.sv
// rtl/search_req_ctrl_pkg.sv - shared types and helpers for the search request stage
package search_pkg;

   localparam int C_CNT_WIDTH = 16;
   localparam int C_TAB_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      HOLD  = 2'd3
   } search_req_st_t;

   // Status part of the result record; address and data widths follow the
   // instance parameters, so they are kept next to this record in the top.
   typedef struct packed {
      logic                   hit;
      logic                   tmo;
      logic [C_TAB_WIDTH-1:0] tab;
   } search_res_t;

   // Statistics counters stick at all-ones instead of wrapping.
   function automatic logic [C_CNT_WIDTH-1:0] sat_inc(input logic [C_CNT_WIDTH-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/search_key_fifo.sv
// rtl/search_key_fifo.sv - show-ahead key FIFO with registered full/empty flags
module search_key_fifo
   import search_pkg::*;
#(
   parameter int C_DEPTH = 4,
   parameter int C_WIDTH = 24
) (
   input  logic               clk_i,
   input  logic               rstn_i,
   input  logic               push_i,
   input  logic [C_WIDTH-1:0] data_i,
   input  logic               pop_i,
   output logic [C_WIDTH-1:0] data_o,
   output logic               full_o,
   output logic               empty_o
);

   localparam int C_AW = $clog2(C_DEPTH);

   logic [C_WIDTH-1:0] mem_q [C_DEPTH];
   logic [C_AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [C_AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [C_AW:0]      count_q, count_d;
   logic               full_q, full_d;
   logic               empty_q, empty_d;
   logic               push_ok, pop_ok;

   // Pointer/occupancy update; a push while full is dropped (no pass-through).
   always_comb begin
      push_ok  = push_i & ~full_q;
      pop_ok   = pop_i & ~empty_q;
      wr_ptr_d = wr_ptr_q + C_AW'(push_ok);
      rd_ptr_d = rd_ptr_q + C_AW'(pop_ok);
      count_d  = count_q;
      if (push_ok && !pop_ok) begin
         count_d = count_q + 1'b1;
      end else if (pop_ok && !push_ok) begin
         count_d = count_q - 1'b1;
      end
      full_d  = (count_d == (C_AW+1)'(C_DEPTH));
      empty_d = (count_d == '0);
   end

   // Control registers; full is held high in reset so no key is taken then.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b1;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

   // Storage array, written only on an accepted push.
   always_ff @(posedge clk_i) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

   assign data_o  = mem_q[rd_ptr_q];
   assign full_o  = full_q;
   assign empty_o = empty_q;

endmodule

// File: rtl/search_req_ctrl.sv
// rtl/search_req_ctrl.sv - issues buffered search keys and collects results with timeout
module search_req_ctrl
   import search_pkg::*;
#(
   parameter int C_NUM_TABLE      = 4,
   parameter int C_RULE_WIDTH     = 24,
   parameter int C_MEM_DATA_WIDTH = 56,
   parameter int C_MEM_ADDR_WIDTH = 8,
   parameter int C_FIFO_DEPTH     = 4,
   parameter int C_TIMEOUT        = 64
) (
   input  logic                                 clk_i,
   input  logic                                 rstn_i,
   input  logic                                 key_vd_i,
   input  logic [C_RULE_WIDTH-1:0]              key_i,
   output logic                                 key_rdy_o,
   input  logic [C_NUM_TABLE-1:0]               ready_i,
   input  logic [C_NUM_TABLE-1:0]               busy_i,
   output logic                                 search_o,
   output logic [C_RULE_WIDTH-1:0]              key_o,
   input  logic                                 hit_vd_i,
   input  logic                                 hit_i,
   input  logic [3:0]                           hit_tab_i,
   input  logic [C_MEM_ADDR_WIDTH-1:0]          hit_addr_i,
   input  logic [C_MEM_DATA_WIDTH-C_RULE_WIDTH-1:0] hit_data_i,
   output logic                                 res_vd_o,
   input  logic                                 res_rdy_i,
   output logic                                 res_hit_o,
   output logic                                 res_tmo_o,
   output logic [C_RULE_WIDTH-1:0]              res_key_o,
   output logic [3:0]                           res_tab_o,
   output logic [C_MEM_ADDR_WIDTH-1:0]          res_addr_o,
   output logic [C_MEM_DATA_WIDTH-C_RULE_WIDTH-1:0] res_data_o,
   output logic [15:0]                          cnt_hit_o,
   output logic [15:0]                          cnt_miss_o,
   output logic [15:0]                          cnt_tmo_o
);

   localparam int C_DW = C_MEM_DATA_WIDTH - C_RULE_WIDTH;
   localparam int C_TW = $clog2(C_TIMEOUT);
   localparam logic [C_TW-1:0] C_TMR_LAST = C_TW'(C_TIMEOUT - 1);

   search_req_st_t          state_q, state_d;
   logic                    search_q, search_d;
   logic [C_RULE_WIDTH-1:0] key_out_q, key_out_d;
   logic [C_RULE_WIDTH-1:0] res_key_q, res_key_d;
   search_res_t             res_q, res_d;
   logic [C_MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [C_DW-1:0]         data_q, data_d;
   logic                    res_vd_q, res_vd_d;
   logic [C_TW-1:0]         timer_q, timer_d;
   logic [C_CNT_WIDTH-1:0]  cnt_hit_q, cnt_hit_d;
   logic [C_CNT_WIDTH-1:0]  cnt_miss_q, cnt_miss_d;
   logic [C_CNT_WIDTH-1:0]  cnt_tmo_q, cnt_tmo_d;

   logic                    fifo_full, fifo_empty, fifo_pop;
   logic [C_RULE_WIDTH-1:0] fifo_head;

   search_key_fifo #(
      .C_DEPTH (C_FIFO_DEPTH),
      .C_WIDTH (C_RULE_WIDTH)
   ) u_key_fifo (
      .clk_i   (clk_i),
      .rstn_i  (rstn_i),
      .push_i  (key_vd_i),
      .data_i  (key_i),
      .pop_i   (fifo_pop),
      .data_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Next-state and datapath: one search in flight, tables sampled only in IDLE.
   always_comb begin
      state_d    = state_q;
      search_d   = 1'b0;
      key_out_d  = key_out_q;
      res_key_d  = res_key_q;
      res_d      = res_q;
      addr_d     = addr_q;
      data_d     = data_q;
      res_vd_d   = res_vd_q;
      timer_d    = timer_q;
      cnt_hit_d  = cnt_hit_q;
      cnt_miss_d = cnt_miss_q;
      cnt_tmo_d  = cnt_tmo_q;
      fifo_pop   = 1'b0;
      case (state_q)
         IDLE: begin
            // Strobe and key are registered here so they line up with ISSUE.
            if (!fifo_empty && (&ready_i) && !(|busy_i)) begin
               state_d   = ISSUE;
               search_d  = 1'b1;
               key_out_d = fifo_head;
            end
         end
         ISSUE: begin
            fifo_pop  = 1'b1;
            res_key_d = fifo_head;
            timer_d   = '0;
            state_d   = WAIT;
         end
         WAIT: begin
            timer_d = timer_q + 1'b1;
            // A result arriving on the expiry cycle still counts as a result.
            if (hit_vd_i) begin
               res_d.hit = hit_i;
               res_d.tmo = 1'b0;
               res_d.tab = hit_tab_i;
               addr_d    = hit_addr_i;
               data_d    = hit_data_i;
               if (hit_i) begin
                  cnt_hit_d = sat_inc(cnt_hit_q);
               end else begin
                  cnt_miss_d = sat_inc(cnt_miss_q);
               end
               res_vd_d = 1'b1;
               state_d  = HOLD;
            end else if (timer_q == C_TMR_LAST) begin
               res_d.hit = 1'b0;
               res_d.tmo = 1'b1;
               res_d.tab = '0;
               addr_d    = '0;
               data_d    = '0;
               cnt_tmo_d = sat_inc(cnt_tmo_q);
               res_vd_d  = 1'b1;
               state_d   = HOLD;
            end
         end
         HOLD: begin
            if (res_rdy_i) begin
               res_vd_d = 1'b0;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, result and statistics registers; reset drops any in-flight work.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state_q    <= IDLE;
         search_q   <= 1'b0;
         key_out_q  <= '0;
         res_key_q  <= '0;
         res_q      <= '0;
         addr_q     <= '0;
         data_q     <= '0;
         res_vd_q   <= 1'b0;
         timer_q    <= '0;
         cnt_hit_q  <= '0;
         cnt_miss_q <= '0;
         cnt_tmo_q  <= '0;
      end else begin
         state_q    <= state_d;
         search_q   <= search_d;
         key_out_q  <= key_out_d;
         res_key_q  <= res_key_d;
         res_q      <= res_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         res_vd_q   <= res_vd_d;
         timer_q    <= timer_d;
         cnt_hit_q  <= cnt_hit_d;
         cnt_miss_q <= cnt_miss_d;
         cnt_tmo_q  <= cnt_tmo_d;
      end
   end

   assign key_rdy_o  = ~fifo_full;
   assign search_o   = search_q;
   assign key_o      = key_out_q;
   assign res_vd_o   = res_vd_q;
   assign res_hit_o  = res_q.hit;
   assign res_tmo_o  = res_q.tmo;
   assign res_key_o  = res_key_q;
   assign res_tab_o  = res_q.tab;
   assign res_addr_o = addr_q;
   assign res_data_o = data_q;
   assign cnt_hit_o  = cnt_hit_q;
   assign cnt_miss_o = cnt_miss_q;
   assign cnt_tmo_o  = cnt_tmo_q;

endmodule

// File: tb/tb_search_req_ctrl.sv
// tb/tb_search_req_ctrl.sv - scoreboard bench for search_req_ctrl
module tb_search_req_ctrl;

   localparam int NT = 4, RW = 24, MDW = 56, AW = 8, DEPTH = 4, T = 64;
   localparam int DW = MDW - RW;

   logic          clk = 1'b0;
   logic          rstn_i;
   logic          key_vd_i;
   logic [RW-1:0] key_i;
   logic          key_rdy_o;
   logic [NT-1:0] ready_i, busy_i;
   logic          search_o;
   logic [RW-1:0] key_o;
   logic          hit_vd_i, hit_i;
   logic [3:0]    hit_tab_i;
   logic [AW-1:0] hit_addr_i;
   logic [DW-1:0] hit_data_i;
   logic          res_vd_o, res_rdy_i, res_hit_o, res_tmo_o;
   logic [RW-1:0] res_key_o;
   logic [3:0]    res_tab_o;
   logic [AW-1:0] res_addr_o;
   logic [DW-1:0] res_data_o;
   logic [15:0]   cnt_hit_o, cnt_miss_o, cnt_tmo_o;

   always #5 clk = ~clk;

   search_req_ctrl #(
      .C_NUM_TABLE(NT), .C_RULE_WIDTH(RW), .C_MEM_DATA_WIDTH(MDW),
      .C_MEM_ADDR_WIDTH(AW), .C_FIFO_DEPTH(DEPTH), .C_TIMEOUT(T)
   ) dut (
      .clk_i(clk), .rstn_i(rstn_i), .key_vd_i(key_vd_i), .key_i(key_i),
      .key_rdy_o(key_rdy_o), .ready_i(ready_i), .busy_i(busy_i),
      .search_o(search_o), .key_o(key_o), .hit_vd_i(hit_vd_i), .hit_i(hit_i),
      .hit_tab_i(hit_tab_i), .hit_addr_i(hit_addr_i), .hit_data_i(hit_data_i),
      .res_vd_o(res_vd_o), .res_rdy_i(res_rdy_i), .res_hit_o(res_hit_o),
      .res_tmo_o(res_tmo_o), .res_key_o(res_key_o), .res_tab_o(res_tab_o),
      .res_addr_o(res_addr_o), .res_data_o(res_data_o), .cnt_hit_o(cnt_hit_o),
      .cnt_miss_o(cnt_miss_o), .cnt_tmo_o(cnt_tmo_o)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   typedef struct {
      logic          hit;
      logic          tmo;
      logic [3:0]    tab;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [RW-1:0] key;
      int            rise;
   } res_rec_t;

   // Reference model state
   res_rec_t      exp_res_q[$];
   logic [RW-1:0] exp_key_q[$];
   int            model_cnt = 0;
   bit            model_busy = 0, exp_search = 0, prev_vd = 0, rst_ok = 0;
   int            cyc = 0;
   int            m_hit = 0, m_miss = 0, m_tmo = 0;

   // Responder state: resp_cnt cycles after the strobe, drive one hit_vd pulse
   int            resp_cnt = 0;
   logic          r_hit;
   logic [3:0]    r_tab;
   logic [AW-1:0] r_addr;
   logic [DW-1:0] r_data;

   // Forced response for directed items (f_k = 0: never respond)
   bit            f_en = 0, f_hit = 0;
   int            f_k = 0;
   logic [3:0]    f_tab = '0;
   logic [AW-1:0] f_addr = '0;
   bit            rdy_rand = 0, gate_rand = 0;

   always @(posedge clk) begin
      cyc    <= cyc + 1;
      rst_ok <= rstn_i;
   end

   // Responder and random environment, driven just after the active edge
   always @(posedge clk) begin
      #1;
      hit_vd_i   = 1'b0;
      hit_i      = 1'($urandom);
      hit_tab_i  = 4'($urandom);
      hit_addr_i = AW'($urandom);
      hit_data_i = DW'($urandom);
      if (resp_cnt == 1) begin
         hit_vd_i   = 1'b1;
         hit_i      = r_hit;
         hit_tab_i  = r_tab;
         hit_addr_i = r_addr;
         hit_data_i = r_data;
         resp_cnt   = 0;
      end else if (resp_cnt > 1) begin
         resp_cnt--;
      end
      if (rdy_rand) res_rdy_i = ($urandom_range(0, 3) != 0);
      if (gate_rand) begin
         ready_i = ($urandom_range(0, 7) == 0) ? NT'($urandom) : {NT{1'b1}};
         busy_i  = ($urandom_range(0, 7) == 0) ? NT'(4'b0010) : '0;
      end
   end

   // Monitor / scoreboard
   res_rec_t      rec, fr;
   logic [RW-1:0] kk;
   int            k;
   bit            exp_next, rsp_hit;

   always @(negedge clk) begin
      if (rst_ok) begin
         chk("key_rdy", key_rdy_o, 64'(model_cnt != DEPTH));
         chk("search_strobe", search_o, exp_search);
         if (search_o) begin
            chk("search_has_key", 64'(exp_key_q.size() != 0), 1);
            if (exp_key_q.size() != 0) begin
               kk = exp_key_q.pop_front();
               chk("key_o", key_o, kk);
               model_cnt--;
               model_busy = 1;
               if (f_en) begin
                  k = f_k; rsp_hit = f_hit; r_tab = f_tab; r_addr = f_addr;
               end else begin
                  case ($urandom_range(0, 9))
                     0:       k = T;
                     1:       k = T + $urandom_range(1, 2);
                     2:       k = 0;
                     default: k = $urandom_range(1, 8);
                  endcase
                  rsp_hit = 1'($urandom);
                  r_tab   = 4'($urandom);
                  r_addr  = AW'($urandom);
               end
               r_hit  = rsp_hit;
               r_data = DW'($urandom);
               rec.key = kk;
               if (k >= 1 && k <= T) begin
                  rec.hit = rsp_hit; rec.tmo = 1'b0; rec.tab = r_tab;
                  rec.addr = r_addr; rec.data = r_data; rec.rise = cyc + k + 1;
               end else begin
                  rec.hit = 1'b0; rec.tmo = 1'b1; rec.tab = '0;
                  rec.addr = '0; rec.data = '0; rec.rise = cyc + T + 1;
               end
               exp_res_q.push_back(rec);
               resp_cnt = k;
            end
         end
         if (res_vd_o) begin
            chk("res_expected", 64'(exp_res_q.size() != 0), 1);
            if (exp_res_q.size() != 0) begin
               fr = exp_res_q[0];
               if (!prev_vd) begin
                  chk("res_rise_cycle", 64'(cyc), 64'(fr.rise));
                  if (fr.tmo) m_tmo++;
                  else if (fr.hit) m_hit++;
                  else m_miss++;
               end
               chk("res_hit", res_hit_o, fr.hit);
               chk("res_tmo", res_tmo_o, fr.tmo);
               chk("res_key", res_key_o, fr.key);
               chk("res_tab", res_tab_o, fr.tab);
               chk("res_addr", res_addr_o, fr.addr);
               chk("res_data", res_data_o, fr.data);
               if (res_rdy_i) fr = exp_res_q.pop_front();
            end
         end
         chk("cnt_hit", cnt_hit_o, 64'(m_hit));
         chk("cnt_miss", cnt_miss_o, 64'(m_miss));
         chk("cnt_tmo", cnt_tmo_o, 64'(m_tmo));
         exp_next = !model_busy && model_cnt > 0 && (&ready_i) && !(|busy_i);
         if (res_vd_o && res_rdy_i) model_busy = 0;
         exp_search = exp_next;
         prev_vd = res_vd_o;
         if (key_vd_i && key_rdy_o) begin
            exp_key_q.push_back(key_i);
            model_cnt++;
         end
      end
   end

   task automatic do_reset();
      @(posedge clk); #1;
      rstn_i = 1'b0;
      @(posedge clk);
      exp_key_q.delete();
      exp_res_q.delete();
      model_cnt = 0; model_busy = 0; exp_search = 0; prev_vd = 0;
      m_hit = 0; m_miss = 0; m_tmo = 0; resp_cnt = 0;
      @(negedge clk);
      chk("rst_search", search_o, 0);
      chk("rst_key_o", key_o, 0);
      chk("rst_res_vd", res_vd_o, 0);
      chk("rst_key_rdy", key_rdy_o, 0);
      chk("rst_res_key", res_key_o, 0);
      chk("rst_res_flags", {res_hit_o, res_tmo_o, res_tab_o}, 0);
      chk("rst_cnts", {cnt_hit_o, cnt_miss_o, cnt_tmo_o}, 0);
      @(posedge clk); #1;
      rstn_i = 1'b1;
   endtask

   task automatic push_key(input logic [RW-1:0] kv);
      bit took = 0;
      @(posedge clk); #1;
      key_i = kv;
      key_vd_i = 1'b1;
      for (int i = 0; i < 400 && !took; i++) begin
         @(negedge clk);
         took = key_rdy_o;
      end
      chk("push_accepted", took, 1);
      @(posedge clk); #1;
      key_vd_i = 1'b0;
   endtask

   task automatic wait_idle();
      bit done = 0;
      for (int i = 0; i < 3000 && !done; i++) begin
         @(negedge clk); #1;
         done = !model_busy && model_cnt == 0 && !exp_search;
      end
      chk("wait_idle_done", done, 1);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rstn_i = 1'b0; key_vd_i = 1'b0; key_i = '0;
      ready_i = '1; busy_i = '0; res_rdy_i = 1'b1;
      hit_vd_i = 1'b0; hit_i = 1'b0; hit_tab_i = '0; hit_addr_i = '0; hit_data_i = '0;
      do_reset();

      // Hit three cycles after the strobe
      f_en = 1; f_k = 3; f_hit = 1; f_tab = 4'd2; f_addr = 8'h3C;
      push_key(24'hA5A5A5);
      wait_idle();
      chk("dir_cnt_hit", cnt_hit_o, 1);

      // Timeout, with a late hit_vd that must be ignored
      f_k = T + 2;
      push_key(24'h123456);
      wait_idle();
      repeat (4) @(negedge clk);
      chk("dir_cnt_tmo", cnt_tmo_o, 1);

      // hit_vd (miss) on the expiry cycle wins over the timeout
      f_k = T; f_hit = 0;
      push_key(24'h0F0F0F);
      wait_idle();
      chk("dir_cnt_miss", cnt_miss_o, 1);
      chk("dir_cnt_tmo2", cnt_tmo_o, 1);

      // Busy table gates issue; FIFO fills
      f_k = 2; f_hit = 1;
      @(posedge clk); #1; busy_i = 4'b0100;
      for (int i = 0; i < 4; i++) push_key(RW'(24'h100 + i));
      repeat (5) @(negedge clk);
      chk("dir_fifo_full", key_rdy_o, 0);
      chk("dir_no_search", search_o, 0);
      @(posedge clk); #1; busy_i = '0;
      wait_idle();

      // Downstream backpressure
      @(posedge clk); #1; res_rdy_i = 1'b0;
      push_key(24'hBEEF01);
      push_key(24'hBEEF02);
      for (int i = 0; i < 100 && !res_vd_o; i++) @(negedge clk);
      repeat (10) @(negedge clk);
      @(posedge clk); #1; res_rdy_i = 1'b1;
      wait_idle();

      // Reset while waiting for a result
      f_k = 0;
      push_key(24'hDEAD00);
      for (int i = 0; i < 20 && !model_busy; i++) @(negedge clk);
      repeat (5) @(negedge clk);
      do_reset();
      f_k = 4; f_hit = 1;
      push_key(24'hC0FFEE);
      wait_idle();
      chk("post_rst_cnt_hit", cnt_hit_o, 1);

      // Randomized traffic
      f_en = 0; rdy_rand = 1; gate_rand = 1;
      for (int n = 0; n < 150; n++) begin
         repeat ($urandom_range(0, 3)) @(posedge clk);
         push_key(RW'($urandom));
      end
      rdy_rand = 0; gate_rand = 0;
      @(posedge clk); #1; res_rdy_i = 1'b1; ready_i = '1; busy_i = '0;
      wait_idle();
      repeat (5) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
